hash_out_mem_writer: RTL and testbench

HASH_OUT_MEM_WRITER -- requirements
Module: hash_out_mem_writer

---
 rtl/hash_out_mem_writer.sv | 114 +++++++++++
 tb/tb_hash_out_mem_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_out_mem_writer.sv
// hash_out_mem_writer: captures the hash core's digest words and writes them
// into a small memory starting at address 0. The digest length (in bits)
// determines how many words are taken; the final partial word is zero-padded
// above the last valid bit. The number of words is clamped to the memory depth.
//
// Handshake: a word transfers on a rising edge where i_data_in_valid and
// o_data_in_ready are both high. o_data_in_ready depends only on the registered
// state, so there is no combinational path from i_data_in_valid to it. The
// producer may drop valid at any time; the block simply waits.
module hash_out_mem_writer #(
    parameter int IO_WIDTH      = 32,
    parameter int MAX_RAM_DEPTH = 4,
    localparam int AW = (MAX_RAM_DEPTH > 1) ? $clog2(MAX_RAM_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [IO_WIDTH-1:0] i_output_length,
    input  logic [IO_WIDTH-1:0] i_data_in,
    input  logic                i_data_in_valid,
    output logic                o_data_in_ready,
    output logic                o_wr_en,
    output logic [AW-1:0]       o_addr,
    output logic [IO_WIDTH-1:0] o_data_out,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_state
);

    localparam int CW = $clog2(MAX_RAM_DEPTH + 1);
    localparam int RW = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
    localparam logic [IO_WIDTH-1:0] WIDTH_V = IO_WIDTH'(IO_WIDTH);
    localparam logic [IO_WIDTH-1:0] DEPTH_V = IO_WIDTH'(MAX_RAM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     n_words;
    logic [CW-1:0]     beat_cnt;
    logic [RW-1:0]     rem_bits;

    logic [IO_WIDTH-1:0] len_q;
    logic [IO_WIDTH-1:0] len_r;
    logic [IO_WIDTH-1:0] need;
    logic [CW-1:0]       start_n;
    logic [RW-1:0]       start_r;
    logic                last_beat;
    logic [IO_WIDTH-1:0] tail_mask;
    logic [IO_WIDTH-1:0] beat_data;

    // Word count / remainder from the requested length, and the masked write data
    always_comb begin
        len_q     = i_output_length / WIDTH_V;
        len_r     = i_output_length % WIDTH_V;
        // Quotient plus one for a partial word; avoids overflow of len+W-1
        need      = len_q + {{(IO_WIDTH-1){1'b0}}, |len_r};
        start_n   = (need > DEPTH_V) ? CW'(MAX_RAM_DEPTH) : CW'(need);
        start_r   = RW'(len_r);
        last_beat = (beat_cnt == (n_words - 1'b1));
        tail_mask = ~({IO_WIDTH{1'b1}} << rem_bits);
        beat_data = (last_beat && (rem_bits != '0)) ? (i_data_in & tail_mask) : i_data_in;
    end

    assign o_data_in_ready = (state == WRITE);
    assign o_busy          = (state != IDLE);
    assign o_done          = (state == DONE);
    assign o_state         = state;

    // Capture FSM with registered memory-write outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_words    <= '0;
            beat_cnt   <= '0;
            rem_bits   <= '0;
            o_wr_en    <= 1'b0;
            o_addr     <= '0;
            o_data_out <= '0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        n_words  <= start_n;
                        rem_bits <= start_r;
                        beat_cnt <= '0;
                        state    <= (start_n != '0) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    if (i_data_in_valid) begin
                        o_wr_en    <= 1'b1;
                        o_addr     <= beat_cnt[AW-1:0];
                        o_data_out <= beat_data;
                        beat_cnt   <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= FLUSH;
                        end
                    end
                end
                // The final write is on the outputs during this cycle
                FLUSH: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_out_mem_writer.sv
// Bench for hash_out_mem_writer: directed captures checked every cycle against
// a counting model of the capture rules, plus literal end-of-capture checks.
module tb_hash_out_mem_writer;

    localparam int W = 32;
    localparam int D = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [W-1:0]  i_output_length;
    logic [W-1:0]  i_data_in;
    logic          i_data_in_valid;
    logic          o_data_in_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_addr;
    logic [W-1:0]  o_data_out;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    hash_out_mem_writer #(.IO_WIDTH(W), .MAX_RAM_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_output_length(i_output_length),
        .i_data_in      (i_data_in),
        .i_data_in_valid(i_data_in_valid),
        .o_data_in_ready(o_data_in_ready),
        .o_wr_en        (o_wr_en),
        .o_addr         (o_addr),
        .o_data_out     (o_data_out),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_state        (o_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_words(input logic [31:0] len);
        longint n;
        n = (longint'(len) + W - 1) / W;
        if (n > D) n = D;
        return int'(n);
    endfunction

    function automatic logic [31:0] keep_low(input logic [31:0] w, input int r);
        logic [31:0] m;
        if (r == 0) return w;
        m = (32'h1 << r) - 32'h1;
        return w & m;
    endfunction

    bit          m_busy, m_tail, m_wr_en, m_done;
    int          m_left, m_beat, m_r;
    logic [31:0] m_addr, m_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_tail <= 0; m_wr_en <= 0; m_done <= 0;
            m_left <= 0; m_beat <= 0; m_r <= 0;
            m_addr <= '0; m_data <= '0;
        end else begin
            m_wr_en <= 0;
            m_done  <= 0;
            if (!m_busy) begin
                if (i_start) begin
                    m_busy <= 1;
                    m_beat <= 0;
                    m_left <= exp_words(i_output_length);
                    m_r    <= int'(i_output_length % W);
                    m_done <= (exp_words(i_output_length) == 0);
                end
            end else if (m_done) begin
                m_busy <= 0;
            end else if (m_tail) begin
                m_tail <= 0;
                m_done <= 1;
            end else if (m_left > 0 && i_data_in_valid) begin
                m_wr_en <= 1;
                m_addr  <= 32'(m_beat);
                m_data  <= (m_left == 1) ? keep_low(i_data_in, m_r) : i_data_in;
                m_beat  <= m_beat + 1;
                m_left  <= m_left - 1;
                if (m_left == 1) m_tail <= 1;
            end
        end
    end

    // ---------------- compare process and write monitor ----------------
    logic [31:0] mem [0:D-1];
    int wr_count = 0;
    int done_count = 0;

    always @(negedge clk) begin
        check("ready", 32'(o_data_in_ready), 32'(m_left > 0));
        check("busy",  32'(o_busy), 32'(m_busy));
        check("done",  32'(o_done), 32'(m_done));
        check("wr_en", 32'(o_wr_en), 32'(m_wr_en));
        check("addr",  32'(o_addr), m_addr);
        check("data",  o_data_out, m_data);
        if (o_wr_en) begin
            wr_count++;
            mem[o_addr] = o_data_out;
        end
        if (o_done) done_count++;
    end

    // ---------------- driver tasks ----------------
    logic [31:0] words [$];
    int base_wr, base_done;

    task automatic start(input logic [31:0] len);
        i_start = 1'b1;
        i_output_length = len;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send(input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            i_data_in = words[k];
            i_data_in_valid = 1'b1;
            @(negedge clk);
            if (gaps) begin
                i_data_in_valid = 1'b0;
                i_data_in = 32'hDEADBEEF;
                @(negedge clk);
            end
        end
        i_data_in_valid = 1'b0;
    endtask

    task automatic mark();
        base_wr = wr_count;
        base_done = done_count;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        i_start = 1'b0;
        i_output_length = '0;
        i_data_in = '0;
        i_data_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(o_wr_en), 32'h0);
        check("rst_busy",  32'(o_busy), 32'h0);
        check("rst_ready", 32'(o_data_in_ready), 32'h0);
        check("rst_data",  o_data_out, 32'h0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Full digest, valid always high
        words = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
        mark();
        start(128);
        send(4, 0);
        repeat (4) @(negedge clk);
        check("s1_writes", 32'(wr_count - base_wr), 32'd4);
        check("s1_done",   32'(done_count - base_done), 32'd1);
        check("s1_mem0",   mem[0], 32'hA0A0A0A0);
        check("s1_mem3",   mem[3], 32'hA3A3A3A3);

        // Partial last word: 40 bits -> keep low 8 bits of word 1
        words = '{32'h11223344, 32'hAABBCCDD};
        mark();
        start(40);
        send(2, 0);
        repeat (4) @(negedge clk);
        check("s2_writes", 32'(wr_count - base_wr), 32'd2);
        check("s2_done",   32'(done_count - base_done), 32'd1);
        check("s2_mem0",   mem[0], 32'h11223344);
        check("s2_mem1",   mem[1], 32'h000000DD);

        // Valid toggling 1/0
        words = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        mark();
        start(128);
        send(4, 1);
        repeat (4) @(negedge clk);
        check("s3_writes", 32'(wr_count - base_wr), 32'd4);
        check("s3_mem2",   mem[2], 32'hC0000003);
        check("s3_mem3",   mem[3], 32'hC0000004);

        // Zero length
        mark();
        start(0);
        repeat (4) @(negedge clk);
        check("s4_writes", 32'(wr_count - base_wr), 32'd0);
        check("s4_done",   32'(done_count - base_done), 32'd1);
        check("s4_busy",   32'(o_busy), 32'h0);

        // 256 bits clamped to depth 4; fifth word offered but not taken
        words = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        mark();
        start(256);
        send(5, 0);
        repeat (4) @(negedge clk);
        check("s5_writes", 32'(wr_count - base_wr), 32'd4);
        check("s5_mem3",   mem[3], 32'h000000B3);
        check("s5_done",   32'(done_count - base_done), 32'd1);

        // Reset mid-capture, then a fresh 64-bit capture with a stray start
        words = '{32'h51515151, 32'h52525252, 32'h53535353, 32'h54545454};
        start(128);
        send(2, 0);
        #2 rst = 1'b0;
        #1;
        check("s6_rst_wr_en", 32'(o_wr_en), 32'h0);
        check("s6_rst_busy",  32'(o_busy), 32'h0);
        check("s6_rst_addr",  32'(o_addr), 32'h0);
        mark();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("s6_idle_writes", 32'(wr_count - base_wr), 32'd0);
        words = '{32'h61616161, 32'h62626262, 32'h63636363};
        start(64);
        start(128);
        send(3, 0);
        repeat (4) @(negedge clk);
        check("s6_writes", 32'(wr_count - base_wr), 32'd2);
        check("s6_done",   32'(done_count - base_done), 32'd1);
        check("s6_mem0",   mem[0], 32'h61616161);
        check("s6_mem1",   mem[1], 32'h62626262);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
